// File: rtl/conv_sequencer_if.sv
// Execute-stage handshake between the core and the convolution sequencer:
// launch operands, pipeline stall, data-memory read port and writeback result.
interface conv_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              start;
  logic [ADDR_W-1:0] in_base;
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] row_stride;
  logic              busy;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              done;
  logic [DATA_W-1:0] result;

  // Sequencer side: it masters the memory read port and reports status.
  modport master (
    input  start, in_base, w_base, row_stride, mem_ack, mem_rdata,
    output busy, mem_req, mem_addr, done, result
  );

  // Core / memory side.
  modport slave (
    output start, in_base, w_base, row_stride, mem_ack, mem_rdata,
    input  busy, mem_req, mem_addr, done, result
  );
endinterface

// File: rtl/conv_sequencer.sv
// K x K multiply-accumulate sequencer for the conv instruction: reads one pixel
// and one weight per tap through the shared read port and returns the wrapped sum.
module conv_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int K      = 3
) (
  input  logic             clk,
  input  logic             rst,
  conv_sequencer_if.master bus
);

  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0]     C_LAST     = CW'(K - 1);
  localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(32'd4);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_IN = 3'd1,
    RD_W  = 3'd2,
    MAC   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state_r;
  logic [DATA_W-1:0] acc_r;
  logic [DATA_W-1:0] pix_r;
  logic [DATA_W-1:0] wt_r;
  logic [CW-1:0]     r_r;
  logic [CW-1:0]     c_r;
  logic [ADDR_W-1:0] stride_r;
  logic [ADDR_W-1:0] row_ptr_r;
  logic [ADDR_W-1:0] in_ptr_r;
  logic [ADDR_W-1:0] w_ptr_r;

  logic signed [DATA_W-1:0] prod_s;
  logic [DATA_W-1:0]        acc_next_s;
  logic [ADDR_W-1:0]        next_row_s;
  logic [ADDR_W-1:0]        next_col_s;

  // MAC datapath and next input addresses; pointers walk rows by stride so no multiplier is needed.
  always_comb begin
    prod_s     = $signed(pix_r) * $signed(wt_r);
    acc_next_s = acc_r + prod_s;
    next_row_s = row_ptr_r + stride_r;
    next_col_s = in_ptr_r + WORD_BYTES;
  end

  // Sequencer FSM; every output is registered so mem_addr stays put until mem_ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      bus.busy     <= 1'b0;
      bus.mem_req  <= 1'b0;
      bus.mem_addr <= {ADDR_W{1'b0}};
      bus.done     <= 1'b0;
      bus.result   <= {DATA_W{1'b0}};
      acc_r        <= {DATA_W{1'b0}};
      pix_r        <= {DATA_W{1'b0}};
      wt_r         <= {DATA_W{1'b0}};
      r_r          <= {CW{1'b0}};
      c_r          <= {CW{1'b0}};
      stride_r     <= {ADDR_W{1'b0}};
      row_ptr_r    <= {ADDR_W{1'b0}};
      in_ptr_r     <= {ADDR_W{1'b0}};
      w_ptr_r      <= {ADDR_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            stride_r     <= bus.row_stride;
            row_ptr_r    <= bus.in_base;
            in_ptr_r     <= bus.in_base;
            w_ptr_r      <= bus.w_base;
            acc_r        <= {DATA_W{1'b0}};
            r_r          <= {CW{1'b0}};
            c_r          <= {CW{1'b0}};
            bus.mem_addr <= bus.in_base;
            bus.mem_req  <= 1'b1;
            bus.busy     <= 1'b1;
            state_r      <= RD_IN;
          end else begin
            state_r <= IDLE;
          end
        end
        RD_IN: begin
          if (bus.mem_ack) begin
            pix_r        <= bus.mem_rdata;
            bus.mem_addr <= w_ptr_r;
            state_r      <= RD_W;
          end else begin
            state_r <= RD_IN;
          end
        end
        RD_W: begin
          if (bus.mem_ack) begin
            wt_r        <= bus.mem_rdata;
            w_ptr_r     <= w_ptr_r + WORD_BYTES;
            bus.mem_req <= 1'b0;
            state_r     <= MAC;
          end else begin
            state_r <= RD_W;
          end
        end
        MAC: begin
          acc_r <= acc_next_s;
          if (c_r == C_LAST) begin
            c_r <= {CW{1'b0}};
            if (r_r == C_LAST) begin
              r_r        <= {CW{1'b0}};
              bus.result <= acc_next_s;
              bus.busy   <= 1'b0;
              bus.done   <= 1'b1;
              state_r    <= DONE;
            end else begin
              r_r          <= r_r + {{(CW-1){1'b0}}, 1'b1};
              row_ptr_r    <= next_row_s;
              in_ptr_r     <= next_row_s;
              bus.mem_addr <= next_row_s;
              bus.mem_req  <= 1'b1;
              state_r      <= RD_IN;
            end
          end else begin
            c_r          <= c_r + {{(CW-1){1'b0}}, 1'b1};
            in_ptr_r     <= next_col_s;
            bus.mem_addr <= next_col_s;
            bus.mem_req  <= 1'b1;
            state_r      <= RD_IN;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          bus.busy    <= 1'b0;
          bus.mem_req <= 1'b0;
          bus.done    <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_sequencer.sv
// Scoreboard bench for conv_sequencer: stimulus pushes expected results/latencies,
// a monitor pops them on done; a simple memory responder models wait states.
module tb_conv_sequencer;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int K      = 3;

  typedef struct {
    logic [31:0] result;
    int          cycle;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  conv_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .K(K)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        sb[$];
  logic [31:0] addr_q[$];
  int          checks   = 0;
  int          passes   = 0;
  int          edge_cnt = 0;
  int          t0       = 0;
  int          wait_cfg = 0;
  logic [31:0] pix_val  = 32'd0;
  logic [31:0] wt_val   = 32'd0;
  logic [31:0] wbase_cfg = 32'd0;
  logic        stray_ack = 1'b0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Memory model: acks after wait_cfg wait cycles; weights live at/above wbase_cfg.
  initial begin
    int wcnt;
    wcnt = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (bus.mem_req) begin
        if (wcnt == wait_cfg) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = (bus.mem_addr >= wbase_cfg) ? wt_val : pix_val;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
        if (stray_ack) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = 32'hDEAD_BEEF;
        end
      end
    end
  end

  // Monitor: address sequence/stability and scoreboard pop on done.
  initial begin
    int          busy_cnt;
    logic        pend;
    logic [31:0] paddr;
    exp_t        e;
    busy_cnt = 0;
    pend     = 1'b0;
    paddr    = 32'd0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        busy_cnt = 0;
        pend     = 1'b0;
      end else begin
        if (bus.busy) busy_cnt++;
        if (pend && bus.mem_req) check("addr_stable", bus.mem_addr, paddr);
        if (bus.mem_req && bus.mem_ack && addr_q.size() != 0)
          check("addr_seq", bus.mem_addr, addr_q.pop_front());
        pend  = bus.mem_req && !bus.mem_ack;
        paddr = bus.mem_addr;
        if (bus.done) begin
          if (sb.size() == 0) begin
            check("spurious_done", {31'b0, bus.done}, 32'd0);
          end else begin
            e = sb.pop_front();
            check("result", bus.result, e.result);
            check("done_cycle", edge_cnt - t0 + 1, e.cycle);
            check("busy_cycles", busy_cnt, e.cycle - 1);
            check("busy_at_done", {31'b0, bus.busy}, 32'd0);
          end
          busy_cnt = 0;
        end
      end
    end
  end

  task automatic launch(input logic [31:0] ib, input logic [31:0] wb, input logic [31:0] rs,
                        input logic [31:0] pv, input logic [31:0] wv, input int waits,
                        input logic [31:0] er, input int ec);
    bus.in_base    = ib;
    bus.w_base     = wb;
    bus.row_stride = rs;
    wbase_cfg      = wb;
    pix_val        = pv;
    wt_val         = wv;
    wait_cfg       = waits;
    bus.start      = 1'b1;
    t0             = edge_cnt + 1;
    sb.push_back('{er, ec});
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check("done_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < 400 && (edge_cnt - t0 + 1) != n; i++) @(negedge clk);
    if ((edge_cnt - t0 + 1) != n) begin
      checks++;
      $display("FAIL wait_cycle: got %0d expected %0d", edge_cnt - t0 + 1, n);
    end
  endtask

  task automatic check_idle(input int n);
    logic bad;
    bad = 1'b0;
    repeat (n) begin
      @(negedge clk);
      #1;
      if (bus.busy || bus.mem_req || bus.done) bad = 1'b1;
    end
    check("stays_idle", {31'b0, bad}, 32'd0);
  endtask

  initial begin
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.in_base    = 32'd0;
    bus.w_base     = 32'd0;
    bus.row_stride = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_result", bus.result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // all ones, zero wait
    launch(32'h1000, 32'h4000, 32'h100, 32'd1, 32'd1, 0, 32'd9, 28);
    wait_done();
    // signed: -2 * 3 * 9 = -54
    launch(32'h1000, 32'h4000, 32'h100, 32'hFFFF_FFFE, 32'd3, 0, 32'hFFFF_FFCA, 28);
    wait_done();
    // address walk: 5 * -1 * 9 = -45
    addr_q = '{32'h100, 32'h200, 32'h104, 32'h204, 32'h108, 32'h208,
               32'h140, 32'h20C, 32'h144, 32'h210, 32'h148, 32'h214,
               32'h180, 32'h218, 32'h184, 32'h21C, 32'h188, 32'h220};
    launch(32'h100, 32'h200, 32'h40, 32'd5, 32'hFFFF_FFFF, 0, 32'hFFFF_FFD3, 28);
    wait_done();
    check("addr_seq_drained", addr_q.size(), 32'd0);
    // two wait states on every read: 9 taps * 7 cycles -> done in cycle 64
    launch(32'h1000, 32'h4000, 32'h100, 32'd1, 32'd1, 2, 32'd9, 64);
    wait_done();
    // product high bits dropped: 0x10000001 * 0x10 -> 0x10 per tap
    launch(32'h1000, 32'h4000, 32'h100, 32'h1000_0001, 32'h10, 0, 32'h90, 28);
    wait_done();

    // start during RD_W of tap 4 and during DONE is ignored
    launch(32'h1000, 32'h4000, 32'h100, 32'd1, 32'd1, 0, 32'd9, 28);
    wait_cyc(11);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_cyc(28);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    check_idle(5);

    // start one cycle after DONE begins a new operation
    @(negedge clk);
    launch(32'h1000, 32'h4000, 32'h100, 32'd1, 32'd1, 0, 32'd9, 28);
    wait_cyc(29);
    launch(32'h1000, 32'h4000, 32'h100, 32'd3, 32'd1, 0, 32'd27, 28);
    wait_done();

    // reset during tap 4, stray ack afterwards, then a clean run
    @(negedge clk);
    launch(32'h1000, 32'h4000, 32'h100, 32'd1, 32'd1, 0, 32'd9, 28);
    wait_cyc(11);
    rst = 1'b1;
    #1;
    check("rst_mid_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_mid_mem_req", {31'b0, bus.mem_req}, 32'd0);
    check("rst_mid_done", {31'b0, bus.done}, 32'd0);
    check("rst_mid_result", bus.result, 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #2 stray_ack = 1'b1;
    @(negedge clk);
    #2 stray_ack = 1'b0;
    check_idle(4);
    @(negedge clk);
    launch(32'h1000, 32'h4000, 32'h100, 32'd2, 32'd2, 0, 32'd36, 28);
    wait_done();
    check_idle(3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/conv_sequencer.md
# conv_sequencer

Multi-cycle controller for the core's convolution instruction (ALU control code 3'b111). It sequences a K×K multiply-accumulate over an input window and a weight kernel held in data memory, and stalls the pipeline while it works. It sits beside the execute-stage ALU. It is started when the ALU decoder emits the conv code, owns the single data-memory read port during the operation, and returns one 32-bit result for writeback.

## Interface
Parameters:
- DATA_W, 32, width of pixels, weights, accumulator and result
- ADDR_W, 32, memory address width
- K, 3, kernel dimension; K×K taps, legal range 1..8

Ports:
- clk  in  1  core clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  conv instruction in execute; sampled only in IDLE
- in_base  in  ADDR_W  byte address of window element (0,0), latched on start
- w_base  in  ADDR_W  byte address of weight element (0,0), latched on start
- row_stride  in  ADDR_W  byte distance between input rows, latched on start
- busy  out  1  pipeline stall request
- mem_req  out  1  read request
- mem_addr  out  ADDR_W  read byte address
- mem_ack  in  1  read complete; mem_rdata valid this cycle
- mem_rdata  in  DATA_W  read data
- done  out  1  one-cycle pulse: result valid
- result  out  DATA_W  accumulated sum, held until the next done

## Operation
- States: IDLE, RD_IN, RD_W, MAC, DONE.
- IDLE, start=1:
  - latch bases and stride
  - acc<=0, r<=0, c<=0
  - next state RD_IN
- IDLE, start=0: remain in IDLE.
- RD_IN:
  - mem_req=1, mem_addr = in_base + r*row_stride + c*4
  - on mem_ack: pix<=mem_rdata, next RD_W
- RD_W:
  - mem_req=1, mem_addr = w_base + (r*K+c)*4
  - on mem_ack: wt<=mem_rdata, next MAC
- MAC:
  - acc <= acc + signed(pix)*signed(wt), keeping the low DATA_W bits (two's-complement wrap, no saturation)
  - if c==K-1: c<=0, r<=r+1; else c<=c+1
  - if (r,c)==(K-1,K-1): result<=new acc, next DONE; else next RD_IN
- DONE: done=1, busy=0, next IDLE unconditionally.
- busy=1 in RD_IN, RD_W and MAC; busy=0 in IDLE and DONE.
- Address arithmetic is modulo 2^ADDR_W.
- start outside IDLE (including in DONE) is ignored.
- Reset values: state=IDLE, busy=0, mem_req=0, mem_addr=0, done=0, result=0. acc, pix, wt, r and c reset to 0.

## Timing
- Memory handshake:
  - mem_ack may arrive in any cycle mem_req is high, including the first cycle (zero wait).
  - mem_addr is held stable while mem_req=1 and until mem_ack.
  - One read is outstanding at most.
  - mem_ack while mem_req=0 is ignored.
- Each tap takes (1+w_in) + (1+w_w) + 1 cycles, where w_in and w_w are the wait cycles of the two reads.
- Zero-wait latency: start is sampled at edge 0. RD_IN is in cycle 1. done is high in cycle 3·K²+1, which is cycle 28 for K=3.
- busy rises in the cycle after start is sampled and falls in the DONE cycle. The pipeline resumes in that same cycle with result valid.
- Reset mid-operation: on rst assertion, state returns to IDLE asynchronously and mem_req, busy and done drop immediately. An mem_ack arriving after reset is ignored. result clears to 0.

## Test plan
- Zero-wait memory, K=3, all pixels=1, all weights=1, start at cycle 0 -> done in cycle 28 only, result=9, busy high in cycles 1–27.
- Signed data: all pixels=−2 (0xFFFFFFFE), all weights=3 -> result=0xFFFFFFCA (−54).
- in_base=0x100, row_stride=0x40, w_base=0x200 -> mem_addr sequence 0x100, 0x200, 0x104, 0x204, 0x108, 0x208, 0x140, 0x20C, … , 0x188, 0x220.
- mem_ack delayed 2 cycles after each request rises -> mem_addr stable throughout each wait, done in cycle 64, result unchanged from the zero-wait case.
- start pulsed during RD_W of tap 4 and again during the DONE cycle -> no restart, exactly one done, result correct. A start one cycle after DONE begins a new operation.
- rst asserted during tap 4, then released, then a new start with pixels=2 and weights=2 -> busy, mem_req and done low during reset, result=0, then a clean run giving result=36.
